// File: rtl/mst_n_seq.sv
// Streaming frame extreme finder: reports the max/min sample of each FRAME_LEN-sample
// frame and its position. Define MST_N_SEQ_SIGNED_EN for two's-complement comparison.
module mst_n_seq #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int IDX_W     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mode,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_num,
  input  logic              i_ready,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_num,
  output logic [IDX_W-1:0]  o_idx
);

  localparam int CNT_W = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] best, best_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              mode_q, cur_mode;
  logic              accept, last, better, gt, lt;

`ifdef MST_N_SEQ_SIGNED_EN
  assign gt = $signed(i_num) > $signed(best);
  assign lt = $signed(i_num) < $signed(best);
`else
  assign gt = i_num > best;
  assign lt = i_num < best;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = (state != DONE);
    o_valid   = (state == DONE);
    accept    = i_valid && o_ready && !i_clear;
    last      = (cnt == CNT_W'(FRAME_LEN - 1));
    // mode is taken live on the first sample, then from the latched copy
    cur_mode  = (state == IDLE) ? i_mode : mode_q;
    better    = cur_mode ? lt : gt;
    best_nxt  = best;
    idx_nxt   = idx;
    if (state == IDLE) begin
      best_nxt = i_num;
      idx_nxt  = '0;
    end else if (better) begin
      best_nxt = i_num;
      idx_nxt  = IDX_W'(cnt);
    end
    if (i_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = last ? DONE : ACC;
        ACC:     if (accept && last) state_nxt = DONE;
        DONE:    if (i_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // result registers load from the combinational update so the last sample
  // is included with one cycle of latency
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      best   <= '0;
      idx    <= '0;
      mode_q <= 1'b0;
      o_num  <= '0;
      o_idx  <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt  <= last ? '0 : cnt + CNT_W'(1);
      best <= best_nxt;
      idx  <= idx_nxt;
      if (state == IDLE) mode_q <= i_mode;
      if (last) begin
        o_num <= best_nxt;
        o_idx <= idx_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mst_n_seq.sv
// Bench for mst_n_seq: frame-level reference model checked every cycle, plus
// directed frames with literal expected results.
module tb_mst_n_seq;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 4;
  localparam int IDX_W     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode = 1'b0, clear = 1'b0, valid = 1'b0, ready = 1'b0;
  logic [DATA_W-1:0] num = '0;
  logic              o_ready, o_valid;
  logic [DATA_W-1:0] o_num;
  logic [IDX_W-1:0]  o_idx;

  int checks = 0;
  int errors = 0;

  mst_n_seq #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_clear(clear),
    .i_valid(valid), .i_num(num), .i_ready(ready),
    .o_ready(o_ready), .o_valid(o_valid), .o_num(o_num), .o_idx(o_idx)
  );

  always #5 clk = ~clk;

  // Reference model: collect a frame's samples, then search the whole frame.
  logic [DATA_W-1:0] q[$];
  logic              m_mode = 1'b0;
  logic              ev = 1'b0;
  logic [DATA_W-1:0] en = '0;
  logic [IDX_W-1:0]  ei = '0;

  function automatic bit beats(logic [DATA_W-1:0] a, logic [DATA_W-1:0] b, logic mn);
`ifdef MST_N_SEQ_SIGNED_EN
    return mn ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
`else
    return mn ? (a < b) : (a > b);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); ev = 1'b0; en = '0; ei = '0;
    end else if (clear) begin
      q.delete(); ev = 1'b0;
    end else if (ev) begin
      if (ready) ev = 1'b0;
    end else if (valid) begin
      if (q.size() == 0) m_mode = mode;
      q.push_back(num);
      if (q.size() == FRAME_LEN) begin
        en = q[0]; ei = '0;
        for (int k = 1; k < FRAME_LEN; k++)
          if (beats(q[k], en, m_mode)) begin en = q[k]; ei = IDX_W'(k); end
        ev = 1'b1;
        q.delete();
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (o_valid !== ev || o_ready !== !ev || o_num !== en || o_idx !== ei) begin
      errors++;
      $display("FAIL model_cmp t=%0t got v=%b r=%b num=%0d idx=%0d required v=%b r=%b num=%0d idx=%0d",
               $time, o_valid, o_ready, o_num, o_idx, ev, !ev, en, ei);
    end
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic send(logic md, logic [DATA_W-1:0] d);
    valid = 1'b1; mode = md; num = d;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic expect_result(string name, int exp_num, int exp_idx);
    int n = 0;
    while (!o_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, "_valid"}, int'(o_valid), 1);
    chk({name, "_num"}, int'(o_num), exp_num);
    chk({name, "_idx"}, int'(o_idx), exp_idx);
  endtask

  task automatic take();
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    chk("take_valid_low", int'(o_valid), 0);
  endtask

  initial begin
    #12;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_num", int'(o_num), 0);
    chk("rst_idx", int'(o_idx), 0);
    #10 rst_n = 1'b1;

    // max, duplicate 200 keeps earliest index; result one cycle after last sample
    send(0, 3); send(0, 200); send(0, 17); send(0, 200);
    chk("lat_valid", int'(o_valid), 1);
    expect_result("max", 200, 1);
    take();

    // min latched on first sample; later mode change ignored; tie keeps idx 1
    send(1, 9); send(1, 4); send(0, 4); send(0, 250);
    expect_result("min", 4, 1);
    take();

    // held result with back-pressure and sample traffic
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    valid = 1'b1; num = 8'h55;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", int'(o_valid), 1);
      chk("hold_ready", int'(o_ready), 0);
      chk("hold_num", int'(o_num), 4);
      chk("hold_idx", int'(o_idx), 3);
    end
    valid = 1'b0;
    take();

    // clear wins over a simultaneous valid sample
    send(0, 50); send(0, 60);
    clear = 1'b1; valid = 1'b1; num = 8'd99;
    @(posedge clk); #1;
    clear = 1'b0; valid = 1'b0;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    expect_result("clr", 4, 3);
    take();

    // reset mid-frame
    send(0, 7); send(0, 8); send(0, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", int'(o_valid), 0);
    chk("rstmid_ready", int'(o_ready), 1);
    chk("rstmid_num", int'(o_num), 0);
    #3 rst_n = 1'b1;
    // reset while holding a result
    send(0, 30); send(0, 40); send(0, 50); send(0, 60);
    chk("pre_rst_valid", int'(o_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstdone_valid", int'(o_valid), 0);
    chk("rstdone_ready", int'(o_ready), 1);
    chk("rstdone_num", int'(o_num), 0);
    chk("rstdone_idx", int'(o_idx), 0);
    #3 rst_n = 1'b1;
    send(0, 10); send(0, 20); send(0, 5); send(0, 1);
    expect_result("post_rst", 20, 1);
    take();

    // signedness boundary
    send(0, 8'h80); send(0, 8'h7F); send(0, 8'h01); send(0, 8'hFF);
`ifdef MST_N_SEQ_SIGNED_EN
    expect_result("sign", 8'h7F, 1);
`else
    expect_result("sign", 8'hFF, 3);
`endif
    take();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
